// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA_ADDR feed a byte FIFO
// that is serialised on TxOut; STATUS_ADDR reads back FIFO/transmitter state.
module uart_tx_mmio #(
  parameter int          CLK_DIV     = 434,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [9:0]  DATA_ADDR   = 10'h3FE,
  parameter logic [9:0]  STATUS_ADDR = 10'h3FF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [9:0]  Addr,
  input  logic [15:0] WrData,
  input  logic        WrEn,
  output logic [15:0] RdData,
  output logic        TxOut,
  output logic        Busy,
  output logic        FifoFull
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic [15:0]     r_rd_data;

  logic            w_empty;
  logic            w_full;
  logic            w_push_req;
  logic            w_clr_req;
  logic            w_push;
  logic            w_pop;
  logic            w_baud_tc;
  logic            w_tx_next;
  logic [15:0]     w_status;
  logic            w_unused_hi;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push_req  = WrEn && (Addr == DATA_ADDR);
  assign w_clr_req   = WrEn && (Addr == STATUS_ADDR);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_baud_tc   = (r_baud == BW'(CLK_DIV - 1));
  assign w_status    = {7'd0, 5'(r_count), r_ovf, Busy, w_full, w_empty};
  assign w_unused_hi = ^WrData[15:8];

  // w_tx_next is the line level for the state being entered, so TxOut is a clean register.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_baud_tc) begin
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_baud_tc) begin
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_tc) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_baud  <= '0;
        r_bit   <= '0;
      end else if (r_state != S_IDLE) begin
        r_baud <= w_baud_tc ? '0 : r_baud + BW'(1);
        if (r_state == S_DATA && w_baud_tc) begin
          r_bit   <= r_bit + 3'd1;
          r_shift <= r_shift >> 1;
        end
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_clr_req)                 r_ovf <= 1'b0;
      else if (w_push_req && !w_push) r_ovf <= 1'b1;
      r_rd_data <= (Addr == STATUS_ADDR) ? w_status : 16'h0000;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= WrData[7:0];
  end

  assign RdData   = r_rd_data;
  assign TxOut    = r_tx;
  assign Busy     = (r_state != S_IDLE);
  assign FifoFull = w_full;

endmodule
